// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a Clk_Gate cell: registered CLK_EN/READY with a
// wake-up settle period, idle hold-off before gating, and a saturating active counter.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int ACT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ,
  input  logic                 FORCE_ON,
  input  logic                 CNT_CLR,
  output logic                 CLK_EN,
  output logic                 READY,
  output logic [ACT_WIDTH-1:0] ACT_CNT
);

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_HOLD} state_t;

  localparam logic [3:0] WAKE_LD = (WAKE_CYCLES > 0) ? 4'(WAKE_CYCLES - 1) : 4'd0;
  localparam logic [3:0] IDLE_LD = (IDLE_CYCLES > 0) ? 4'(IDLE_CYCLES - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       want;

  assign want = REQ | FORCE_ON;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_OFF;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_OFF: begin
        if (want) begin
          state_nxt = S_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      // WAKE runs to completion regardless of want, so bursts are never shorter
      // than the settle period.
      S_WAKE: begin
        if (cnt == 4'd0) state_nxt = S_ON;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ON: begin
        if (!want) begin
          if (IDLE_CYCLES == 0) begin
            state_nxt = S_OFF;
          end else begin
            state_nxt = S_HOLD;
            cnt_nxt   = IDLE_LD;
          end
        end
      end
      S_HOLD: begin
        if (want)                state_nxt = S_ON;
        else if (cnt == 4'd0)    state_nxt = S_OFF;
        else                     cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Outputs are flops fed from next state so the gate-cell enable is glitch-free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CLK_EN <= 1'b0;
      READY  <= 1'b0;
    end else begin
      CLK_EN <= (state_nxt != S_OFF);
      READY  <= (state_nxt == S_ON) || (state_nxt == S_HOLD);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       ACT_CNT <= '0;
    else if (CNT_CLR)               ACT_CNT <= '0;
    else if (CLK_EN && !(&ACT_CNT)) ACT_CNT <= ACT_CNT + ACT_WIDTH'(1);
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: expected edge-by-edge outputs are queued as
// stimulus is planned and compared after each clock edge.
module tb_clk_gate_ctrl;

  logic        CLK = 1'b0, RST = 1'b0, REQ = 1'b0, FORCE_ON = 1'b0, CNT_CLR = 1'b0;
  logic        CLK_EN, READY;
  logic [15:0] ACT_CNT;
  logic        rst2 = 1'b0, req2 = 1'b0;
  logic        en2, rdy2;
  logic [3:0]  act2;

  always #5 CLK = ~CLK;

  clk_gate_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON), .CNT_CLR(CNT_CLR),
    .CLK_EN(CLK_EN), .READY(READY), .ACT_CNT(ACT_CNT)
  );

  // narrow counter, no idle hold-off
  clk_gate_ctrl #(.IDLE_CYCLES(0), .WAKE_CYCLES(2), .ACT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RST(rst2), .REQ(req2), .FORCE_ON(1'b0), .CNT_CLR(1'b0),
    .CLK_EN(en2), .READY(rdy2), .ACT_CNT(act2)
  );

  typedef struct {
    int    e;
    int    inst;
    int    en;
    int    rdy;
    int    act;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // keeps the queue ordered by edge; -1 marks a don't-care field
  task automatic push_exp(input int e, input int inst, input int en, input int rdy,
                          input int act, input string tag);
    exp_t x;
    int   i;
    x = '{e: e, inst: inst, en: en, rdy: rdy, act: act, tag: tag};
    i = 0;
    while (i < sb.size() && sb[i].e <= e) i++;
    sb.insert(i, x);
  endtask

  task automatic push_win(input int lo, input int hi, input int on, input int off,
                          input int rdy_on, input string tag);
    for (int e = lo; e <= hi; e++)
      push_exp(e, 0, (e >= on && e < off) ? 1 : 0, (e >= rdy_on && e < off) ? 1 : 0, -1, tag);
  endtask

  task automatic step();
    exp_t x;
    @(posedge CLK);
    edge_n++;
    @(negedge CLK);
    while (sb.size() > 0 && sb[0].e == edge_n) begin
      x = sb.pop_front();
      if (x.en >= 0)
        chk($sformatf("%s_en@%0d", x.tag, x.e), x.inst ? 32'(en2) : 32'(CLK_EN), x.en);
      if (x.rdy >= 0)
        chk($sformatf("%s_rdy@%0d", x.tag, x.e), x.inst ? 32'(rdy2) : 32'(READY), x.rdy);
      if (x.act >= 0)
        chk($sformatf("%s_act@%0d", x.tag, x.e), x.inst ? 32'(act2) : 32'(ACT_CNT), x.act);
    end
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int b, p, f, c, r, d, s, k;

    #1;
    chk("rst_en", CLK_EN, 0);
    chk("rst_rdy", READY, 0);
    chk("rst_act", ACT_CNT, 0);
    step();
    step();
    RST = 1'b1;

    // basic wake, steady run, gate-off
    b = edge_n;
    push_win(b + 1, b + 25, b + 2, b + 24, b + 4, "wake");
    push_exp(b + 1, 0, -1, -1, 0, "wake");
    push_exp(b + 3, 0, -1, -1, 1, "wake");
    push_exp(b + 24, 0, -1, -1, 22, "wake");
    push_exp(b + 25, 0, -1, -1, 22, "wake");
    step_to(b + 1);
    REQ = 1'b1;
    step_to(b + 19);
    REQ = 1'b0;
    step_to(b + 25);

    // re-request during HOLD restarts the idle timer
    b = edge_n + 2;
    push_win(b - 1, b + 15, b, b + 14, b + 2, "hold_rereq");
    push_exp(b + 14, 0, -1, -1, 36, "hold_rereq");
    step_to(b - 1);
    REQ = 1'b1;
    step_to(b + 4);
    REQ = 1'b0;
    step_to(b + 6);
    REQ = 1'b1;
    step_to(b + 9);
    REQ = 1'b0;
    step_to(b + 15);

    // single-cycle pulse gives the minimum burst
    p = edge_n + 2;
    push_win(p - 1, p + 8, p, p + 7, p + 2, "pulse");
    push_exp(p + 7, 0, -1, -1, 43, "pulse");
    step_to(p - 1);
    REQ = 1'b1;
    step();
    REQ = 1'b0;
    step_to(p + 8);

    // FORCE_ON for 100 cycles, then a counter clear while enabled
    f = edge_n + 2;
    c = f + 100;
    push_win(f - 1, c + 8, f, c + 7, f + 2, "force");
    push_exp(c - 1, 0, -1, -1, 142, "force");
    push_exp(c, 0, -1, -1, 0, "force_clr");
    push_exp(c + 1, 0, -1, -1, 1, "force_clr");
    push_exp(c + 2, 0, -1, -1, 2, "force_clr");
    push_exp(c + 7, 0, -1, -1, 7, "force_clr");
    step_to(f - 1);
    FORCE_ON = 1'b1;
    step_to(c - 1);
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    step_to(c + 2);
    FORCE_ON = 1'b0;
    step_to(c + 8);

    // asynchronous reset two cycles into HOLD
    r = edge_n + 2;
    d = r + 4;
    push_win(r - 1, d + 2, r, d + 100, r + 2, "pre_rst");
    step_to(r - 1);
    REQ = 1'b1;
    step_to(d - 1);
    REQ = 1'b0;
    step_to(d + 2);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_en", CLK_EN, 0);
    chk("async_rst_rdy", READY, 0);
    chk("async_rst_act", ACT_CNT, 0);
    step();
    RST = 1'b1;
    b = edge_n;
    push_win(b + 1, b + 12, b + 2, b + 10, b + 4, "rewake");
    push_exp(b + 1, 0, -1, -1, 0, "rewake");
    push_exp(b + 3, 0, -1, -1, 1, "rewake");
    step_to(b + 1);
    REQ = 1'b1;
    step_to(b + 5);
    REQ = 1'b0;
    step_to(b + 12);

    // 4-bit counter saturation and zero idle hold-off
    chk("sat_rst_en", en2, 0);
    chk("sat_rst_act", act2, 0);
    rst2 = 1'b1;
    s = edge_n + 2;
    k = s + 30;
    push_exp(s - 1, 1, 0, 0, 0, "sat");
    push_exp(s, 1, 1, 0, 0, "sat");
    push_exp(s + 2, 1, 1, 1, 2, "sat");
    push_exp(s + 14, 1, 1, 1, 14, "sat");
    push_exp(s + 15, 1, 1, 1, 15, "sat");
    push_exp(s + 16, 1, 1, 1, 15, "sat");
    push_exp(k - 1, 1, 1, 1, 15, "sat");
    push_exp(k, 1, 0, 0, 15, "idle0");
    push_exp(k + 1, 1, 0, 0, -1, "idle0");
    step_to(s - 1);
    req2 = 1'b1;
    step_to(k - 1);
    req2 = 1'b0;
    step_to(k + 1);

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
